// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port data memory.
// Handshake: a requester raises req (with we/addr/wdata) and the arbiter samples it in IDLE;
// gnt marks the one cycle the memory is driven for it, done pulses the cycle after, with rdata valid.
interface dmem_arbiter_if;
  logic        init_start;
  logic        init_busy;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_done;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_done;
  logic [31:0] m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  init_start, m0_req, m0_we, m0_addr, m0_wdata,
           m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    output init_busy, m0_gnt, m0_done, m0_rdata, m1_gnt, m1_done, m1_rdata,
           mem_we, mem_addr, mem_wdata
  );

  modport master (
    output init_start, m0_req, m0_we, m0_addr, m0_wdata,
           m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    input  init_busy, m0_gnt, m0_done, m0_rdata, m1_gnt, m1_done, m1_rdata,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory, with a
// zero-fill sweep of the whole memory after reset or on init_start.
module dmem_arbiter #(
  parameter int WORDS = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_IDLE = 2'd1, S_ACC = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;
  logic             r_win;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;
  logic             r_done0;
  logic             r_done1;
  logic             w_any;
  logic             w_pick;
  logic             w_idx_last;

  // On a tie the requester that was not granted last wins.
  assign w_any      = bus.m0_req | bus.m1_req;
  assign w_pick     = (bus.m0_req & bus.m1_req) ? ~r_last : bus.m1_req;
  assign w_idx_last = (r_idx == IDX_W'(WORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (w_idx_last) w_next = S_IDLE;
      S_IDLE: begin
        if (bus.init_start) w_next = S_INIT;
        else if (w_any)     w_next = S_ACC;
      end
      S_ACC:   w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  // The sweep outputs are held off while reset is asserted so the memory is never written in reset.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.init_busy = 1'b0;
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    case (r_state)
      S_INIT: begin
        if (reset) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = 32'({r_idx, 2'b00});
          bus.init_busy = 1'b1;
        end
      end
      S_ACC: begin
        bus.mem_we    = r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.m0_gnt    = ~r_win;
        bus.m1_gnt    = r_win;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= '0;
      r_last   <= 1'b1;
      r_win    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
    end else begin
      r_done0 <= (r_state == S_ACC) & ~r_win;
      r_done1 <= (r_state == S_ACC) & r_win;
      case (r_state)
        S_INIT: r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
        S_IDLE: begin
          if (!bus.init_start && w_any) begin
            r_win   <= w_pick;
            r_we    <= w_pick ? bus.m1_we    : bus.m0_we;
            r_addr  <= w_pick ? bus.m1_addr  : bus.m0_addr;
            r_wdata <= w_pick ? bus.m1_wdata : bus.m0_wdata;
          end
        end
        S_ACC: begin
          r_last <= r_win;
          if (!r_we) begin
            if (r_win) r_rdata1 <= bus.mem_rdata;
            else       r_rdata0 <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m0_done  = r_done0;
  assign bus.m1_done  = r_done1;
  assign bus.m0_rdata = r_rdata0;
  assign bus.m1_rdata = r_rdata1;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed and randomized accesses against a word-array
// memory reference with per-requester expected read data and round-robin order.
module tb_dmem_arbiter;
  localparam int WORDS = 1024;
  localparam int IDX_W = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  logic [1:0] init_code;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.WORDS(WORDS), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: combinational read, write on rising edge.
  logic [31:0] mem_arr [WORDS];
  assign bus.mem_rdata = mem_arr[bus.mem_addr[IDX_W+1:2]];
  always @(posedge clk) if (bus.mem_we) mem_arr[bus.mem_addr[IDX_W+1:2]] <= bus.mem_wdata;

  logic [31:0] ref_mem [WORDS];
  logic [31:0] exp_rd  [2];
  int          last_gnt;
  logic        op_we   [2];
  logic [31:0] op_a    [2];
  logic [31:0] op_d    [2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int m);
    return (m == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] gnt_v();
    return {bus.m1_gnt, bus.m0_gnt};
  endfunction

  function automatic logic [1:0] done_v();
    return {bus.m1_done, bus.m0_done};
  endfunction

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {bus.init_busy, bus.mem_we, bus.mem_addr, bus.mem_wdata, gnt_v()}, 128'h0);
  endtask

  // Expects WORDS consecutive zero-fill cycles starting in the current cycle.
  task automatic check_sweep(input bit rnd);
    for (int c = 0; c < WORDS; c++) begin
      check("sweep", {bus.init_busy, bus.mem_we, bus.mem_addr, bus.mem_wdata, gnt_v(), done_v()},
            {1'b1, 1'b1, 32'(c * 4), 32'h0, 2'b00, 2'b00});
      if (rnd) begin
        bus.m0_req     = 1'($urandom_range(0, 1));
        bus.m1_req     = 1'($urandom_range(0, 1));
        bus.init_start = 1'($urandom_range(0, 1));
      end
      step();
    end
    if (rnd) begin
      bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.init_start = 1'b0;
    end
    for (int w = 0; w < WORDS; w++) ref_mem[w] = 32'h0;
  endtask

  // Called in requester m's grant cycle; returns in its done cycle.
  task automatic serve(input int m);
    logic [IDX_W-1:0] idx;
    idx = op_a[m][IDX_W+1:2];
    check("gnt", {gnt_v(), bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.init_busy},
          {oh(m), op_we[m], op_a[m], op_d[m], 1'b0});
    if (op_we[m]) ref_mem[idx] = op_d[m];
    else          exp_rd[m]    = ref_mem[idx];
    last_gnt = m;
    drive(m, 1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom());
    bus.init_start = 1'($urandom_range(0, 1));
    step();
    bus.init_start = 1'b0;
    check("done", {done_v(), gnt_v(), bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.init_busy},
          {oh(m), 2'b00, 1'b0, 32'h0, 32'h0, 1'b0});
    check("rdata", {bus.m1_rdata, bus.m0_rdata}, {exp_rd[1], exp_rd[0]});
  endtask

  task automatic run_op(input logic [1:0] rq);
    int first;
    drive(0, rq[0], op_we[0], op_a[0], op_d[0]);
    drive(1, rq[1], op_we[1], op_a[1], op_d[1]);
    step();
    if (rq == 2'b11) begin
      first = (last_gnt == 1) ? 0 : 1;
      serve(first);
      step();
      serve(1 - first);
    end else begin
      serve(rq[1] ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.init_start = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int w = 0; w < WORDS; w++) mem_arr[w] = $urandom();
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; last_gnt = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {bus.mem_we, bus.mem_addr, bus.mem_wdata, gnt_v(), done_v(), bus.m1_rdata, bus.m0_rdata}, 128'h0);

    reset = 1'b1;
    #1;
    init_code = dbg_state;
    check_sweep(1'b1);
    check_idle("post_sweep");
    check("dbg_state_left_init", {127'h0, dbg_state !== init_code}, 128'h1);

    // Directed write then read of the same word by the other requester.
    op_we[0] = 1'b1; op_a[0] = 32'h10; op_d[0] = 32'hDEADBEEF;
    run_op(2'b01);
    op_we[1] = 1'b0; op_a[1] = 32'h10; op_d[1] = 32'h0;
    run_op(2'b10);
    check("m1_read_dead", bus.m1_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 60; i++) begin
      for (int m = 0; m < 2; m++) begin
        op_we[m] = 1'($urandom_range(0, 1));
        op_a[m]  = $urandom() & 32'hFFFF_F03C;
        op_d[m]  = $urandom();
      end
      run_op(2'($urandom_range(1, 3)));
    end

    // Both requests held high: grants alternate, one done every two cycles.
    begin
      int w;
      op_we[0] = 1'b1; op_a[0] = 32'h100; op_d[0] = $urandom();
      op_we[1] = 1'b1; op_a[1] = 32'h200; op_d[1] = $urandom();
      drive(0, 1'b1, op_we[0], op_a[0], op_d[0]);
      drive(1, 1'b1, op_we[1], op_a[1], op_d[1]);
      step();
      w = (last_gnt == 1) ? 0 : 1;
      for (int k = 0; k < 4; k++) begin
        check("held_gnt", {gnt_v(), done_v(), bus.mem_addr}, {oh(w), 2'b00, op_a[w]});
        ref_mem[op_a[w][IDX_W+1:2]] = op_d[w];
        last_gnt = w;
        if (k == 3) begin
          bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        end
        step();
        check("held_done", {gnt_v(), done_v()}, {2'b00, oh(w)});
        w = 1 - w;
        if (k < 3) step();
      end
    end

    // Reset in the middle of an access.
    op_we[1] = 1'b1; op_a[1] = 32'h40; op_d[1] = 32'h12345678;
    drive(1, 1'b1, op_we[1], op_a[1], op_d[1]);
    step();
    check("acc_before_rst", gnt_v(), 2'b10);
    reset = 1'b0;
    #1;
    check("rst_in_acc", {gnt_v(), bus.mem_we, bus.mem_addr, bus.init_busy}, 128'h0);
    bus.m1_req = 1'b0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; last_gnt = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_no_done", {done_v(), gnt_v(), bus.m1_rdata, bus.m0_rdata}, 128'h0);
    end
    reset = 1'b1;
    #1;
    check_sweep(1'b0);
    check_idle("post_rst_sweep");

    // init_start beats a simultaneous request; the request is served after the sweep.
    op_we[0] = 1'b1; op_a[0] = 32'h80; op_d[0] = $urandom();
    bus.init_start = 1'b1;
    drive(0, 1'b1, op_we[0], op_a[0], op_d[0]);
    step();
    bus.init_start = 1'b0;
    check_sweep(1'b0);
    check_idle("idle_after_init");
    step();
    serve(0);
    op_we[1] = 1'b0; op_a[1] = 32'h80; op_d[1] = 32'h0;
    run_op(2'b10);
    check("m1_read_after_init", bus.m1_rdata, op_d[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
